// File: rtl/sys_cmd_decoder.sv
// Frame-command decoder between the UART receiver and the RF / ALU / TX FIFO.
// Parses AA (RF write), BB (RF read), CC (ALU with operands) and DD (ALU only) frames.
module sys_cmd_decoder #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_FUN_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]     RF_RdData,
   input  logic                      RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   input  logic                      FIFO_FULL,
   output logic                      RF_WrEn,
   output logic                      RF_RdEn,
   output logic [ADDR_WIDTH-1:0]     RF_Address,
   output logic [DATA_WIDTH-1:0]     RF_WrData,
   output logic                      ALU_EN,
   output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
   output logic                      CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OP_A     = 4'd5,
      OP_B     = 4'd6,
      FUN      = 4'd7,
      ALU_WAIT = 4'd8,
      TX_LSB   = 4'd9,
      TX_MSB   = 4'd10,
      TX_RD    = 4'd11
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

   state_t                     state_r, state_s;
   logic [ADDR_WIDTH-1:0]      addr_r, addr_s;
   logic [DATA_WIDTH-1:0]      wr_data_r, wr_data_s;
   logic                       wr_en_r, wr_en_s;
   logic                       rd_en_r, rd_en_s;
   logic                       alu_en_r, alu_en_s;
   logic [ALU_FUN_WIDTH-1:0]   alu_fun_r, alu_fun_s;
   logic                       cge_r, cge_s;
   logic [DATA_WIDTH-1:0]      tx_data_r, tx_data_s;
   logic                       tx_vld_r, tx_vld_s;
   logic [2*DATA_WIDTH-1:0]    result_r, result_s;
   logic                       tx_ok_s;

   // A TX byte goes out only when the FIFO has room and the previous strobe has ended.
   assign tx_ok_s = !FIFO_FULL && !tx_vld_r;

   // Next-state and next-output decode; strobes default low so each lasts one cycle.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      wr_data_s = wr_data_r;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      alu_en_s  = alu_en_r;
      alu_fun_s = alu_fun_r;
      cge_s     = cge_r;
      tx_data_s = tx_data_r;
      tx_vld_s  = 1'b0;
      result_s  = result_r;
      case (state_r)
         IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  CMD_WR:     state_s = WR_ADDR;
                  CMD_RD:     state_s = RD_ADDR;
                  CMD_ALU_OP: state_s = OP_A;
                  CMD_ALU:    state_s = FUN;
                  default:    state_s = IDLE;
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_s = WR_DATA;
            end else begin
               state_s = WR_ADDR;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_data_s = RX_P_DATA;
               wr_en_s   = 1'b1;
               state_s   = IDLE;
            end else begin
               state_s = WR_DATA;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_s = 1'b1;
               state_s = RD_WAIT;
            end else begin
               state_s = RD_ADDR;
            end
         end
         RD_WAIT: begin
            if (RF_RdData_VLD) begin
               result_s = {{DATA_WIDTH{1'b0}}, RF_RdData};
               state_s  = TX_RD;
            end else begin
               state_s = RD_WAIT;
            end
         end
         OP_A, OP_B: begin
            if (RX_D_VLD) begin
               addr_s    = (state_r == OP_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
               wr_data_s = RX_P_DATA;
               wr_en_s   = 1'b1;
               state_s   = (state_r == OP_A) ? OP_B : FUN;
            end else begin
               state_s = state_r;
            end
         end
         FUN: begin
            if (RX_D_VLD) begin
               alu_fun_s = RX_P_DATA[ALU_FUN_WIDTH-1:0];
               alu_en_s  = 1'b1;
               cge_s     = 1'b1;
               state_s   = ALU_WAIT;
            end else begin
               state_s = FUN;
            end
         end
         ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               result_s = ALU_OUT;
               alu_en_s = 1'b0;
               cge_s    = 1'b0;
               state_s  = TX_LSB;
            end else begin
               state_s = ALU_WAIT;
            end
         end
         TX_LSB, TX_MSB, TX_RD: begin
            if (tx_ok_s) begin
               tx_data_s = (state_r == TX_MSB) ? result_r[2*DATA_WIDTH-1:DATA_WIDTH]
                                               : result_r[DATA_WIDTH-1:0];
               tx_vld_s  = 1'b1;
               state_s   = (state_r == TX_LSB) ? TX_MSB : IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s  = IDLE;
            alu_en_s = 1'b0;
            cge_s    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything, discarding any pending result.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r   <= IDLE;
         addr_r    <= '0;
         wr_data_r <= '0;
         wr_en_r   <= 1'b0;
         rd_en_r   <= 1'b0;
         alu_en_r  <= 1'b0;
         alu_fun_r <= '0;
         cge_r     <= 1'b0;
         tx_data_r <= '0;
         tx_vld_r  <= 1'b0;
         result_r  <= '0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         wr_data_r <= wr_data_s;
         wr_en_r   <= wr_en_s;
         rd_en_r   <= rd_en_s;
         alu_en_r  <= alu_en_s;
         alu_fun_r <= alu_fun_s;
         cge_r     <= cge_s;
         tx_data_r <= tx_data_s;
         tx_vld_r  <= tx_vld_s;
         result_r  <= result_s;
      end
   end

   assign RF_WrEn     = wr_en_r;
   assign RF_RdEn     = rd_en_r;
   assign RF_Address  = addr_r;
   assign RF_WrData   = wr_data_r;
   assign ALU_EN      = alu_en_r;
   assign ALU_FUN     = alu_fun_r;
   assign CLK_GATE_EN = cge_r;
   assign TX_P_DATA   = tx_data_r;
   assign TX_D_VLD    = tx_vld_r;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Self-checking bench for sys_cmd_decoder: table of command frames, RF/ALU models,
// and a scoreboard of expected RF, ALU and TX events checked by a negedge monitor.
module tb_sys_cmd_decoder;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RX_P_DATA = 8'h00;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  RF_RdData = 8'h00;
   logic        RF_RdData_VLD = 1'b0;
   logic [15:0] ALU_OUT = 16'h0000;
   logic        ALU_OUT_VLD = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
   logic [3:0]  RF_Address, ALU_FUN;
   logic [7:0]  RF_WrData, TX_P_DATA;

   sys_cmd_decoder dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0][7:0]  b;
      int               nb;
      logic [7:0]       rd_data;
      logic [15:0]      alu_res;
      int               full_cyc;
      int               n_wr;
      logic [1:0][11:0] wr;
      int               n_rd;
      logic [3:0]       rd_a;
      int               n_alu;
      logic [3:0]       fun;
      int               n_tx;
      logic [1:0][7:0]  tx;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_wr[$];
   logic [3:0]  exp_rd[$];
   logic [3:0]  exp_alu[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  model_rd = 8'h00;
   logic        alu_busy = 1'b0;
   int          alu_cnt = 0;
   logic        tx_prev = 1'b0, full_prev = 1'b0, alu_en_prev = 1'b0, alu_vld_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] b, input int nb, input logic [7:0] rd,
                               input logic [15:0] res, input int full, input int n_wr,
                               input logic [23:0] wr, input int n_rd, input logic [3:0] rd_a,
                               input int n_alu, input logic [3:0] fun, input int n_tx,
                               input logic [15:0] tx);
      vec_t v;
      v.b = b; v.nb = nb; v.rd_data = rd; v.alu_res = res; v.full_cyc = full;
      v.n_wr = n_wr; v.wr = wr; v.n_rd = n_rd; v.rd_a = rd_a;
      v.n_alu = n_alu; v.fun = fun; v.n_tx = n_tx; v.tx = tx;
      return v;
   endfunction

   // RF model: read data valid one cycle after the read strobe.
   always @(posedge CLK) begin
      RF_RdData_VLD <= RF_RdEn;
      RF_RdData     <= model_rd;
   end

   // ALU model: result valid a few cycles after enable, once per enable.
   always @(posedge CLK) begin
      ALU_OUT_VLD <= 1'b0;
      if (!ALU_EN) begin
         alu_busy <= 1'b0;
         alu_cnt  <= 0;
      end else if (!alu_busy) begin
         alu_busy <= 1'b1;
         alu_cnt  <= 3;
      end else if (alu_cnt != 0) begin
         alu_cnt <= alu_cnt - 1;
         if (alu_cnt == 1) ALU_OUT_VLD <= 1'b1;
      end
   end

   // Monitor: compare every strobe against the scoreboard, away from the clock edge.
   always @(negedge CLK) begin
      if (RST) begin
         if (RF_WrEn) begin
            if (exp_wr.size() == 0) check("unexpected_wr", 1, 0);
            else check("rf_write", {RF_Address, RF_WrData}, exp_wr.pop_front());
            check("wr_exclusive", {RF_RdEn, ALU_EN}, 0);
         end
         if (RF_RdEn) begin
            if (exp_rd.size() == 0) check("unexpected_rd", 1, 0);
            else check("rf_read_addr", RF_Address, exp_rd.pop_front());
            check("rd_exclusive", {RF_WrEn, ALU_EN}, 0);
         end
         if (ALU_EN && !alu_en_prev) begin
            if (exp_alu.size() == 0) check("unexpected_alu", 1, 0);
            else check("alu_fun", ALU_FUN, exp_alu.pop_front());
            check("clk_gate_with_alu_en", CLK_GATE_EN, 1);
         end
         if (alu_vld_prev) check("alu_off_after_vld", {ALU_EN, CLK_GATE_EN}, 0);
         if (TX_D_VLD) begin
            if (exp_tx.size() == 0) check("unexpected_tx", 1, 0);
            else check("tx_byte", TX_P_DATA, exp_tx.pop_front());
            check("tx_single_pulse", tx_prev, 0);
            check("tx_not_when_full", full_prev, 0);
         end
      end
      tx_prev      = TX_D_VLD;
      full_prev    = FIFO_FULL;
      alu_en_prev  = ALU_EN;
      alu_vld_prev = ALU_OUT_VLD;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size()) != 0 && k < 300) begin
         @(posedge CLK);
         k++;
      end
      check("drain_pending", exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size(), 0);
      repeat (4) @(posedge CLK);
   endtask

   task automatic apply(input vec_t v);
      model_rd = v.rd_data;
      ALU_OUT  = v.alu_res;
      for (int i = 0; i < v.n_wr; i++) exp_wr.push_back(v.wr[i]);
      if (v.n_rd > 0) exp_rd.push_back(v.rd_a);
      if (v.n_alu > 0) exp_alu.push_back(v.fun);
      for (int i = 0; i < v.n_tx; i++) exp_tx.push_back(v.tx[i]);
      if (v.full_cyc > 0) FIFO_FULL = 1'b1;
      for (int i = 0; i < v.nb; i++) send_byte(v.b[i]);
      if (v.full_cyc > 0) begin
         repeat (v.full_cyc) @(posedge CLK);
         #1;
         check("tx_held_while_full", exp_tx.size(), v.n_tx);
         check("alu_started_while_full", exp_alu.size(), 0);
         FIFO_FULL = 1'b0;
      end
      wait_drain();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = mk(32'h00_95_04_AA, 3, 8'h00, 16'h0000, 0,  1, 24'h000_495, 0, 4'h0, 0, 4'h0, 0, 16'h0000);
      vecs[1] = mk(32'h00_00_04_BB, 2, 8'h95, 16'h0000, 0,  0, 24'h000_000, 1, 4'h4, 0, 4'h0, 1, 16'h0095);
      vecs[2] = mk(32'h00_85_8A_CC, 4, 8'h00, 16'h010F, 0,  2, 24'h185_08A, 0, 4'h0, 1, 4'h0, 2, 16'h010F);
      vecs[3] = mk(32'h00_00_02_DD, 2, 8'h00, 16'h7552, 20, 0, 24'h000_000, 0, 4'h0, 1, 4'h2, 2, 16'h7552);
      vecs[4] = mk(32'h33_14_AA_5A, 4, 8'h00, 16'h0000, 0,  1, 24'h000_433, 0, 4'h0, 0, 4'h0, 0, 16'h0000);
      vecs[5] = mk(32'h00_C3_1F_AA, 3, 8'h00, 16'h0000, 0,  1, 24'h000_FC3, 0, 4'h0, 0, 4'h0, 0, 16'h0000);
      vecs[6] = mk(32'h00_00_0A_BB, 2, 8'h3C, 16'h0000, 0,  0, 24'h000_000, 1, 4'hA, 0, 4'h0, 1, 16'h003C);
      vecs[7] = mk(32'h07_01_FF_CC, 4, 8'h00, 16'hABCD, 0,  2, 24'h101_0FF, 0, 4'h0, 1, 4'h7, 2, 16'hABCD);

      repeat (3) @(posedge CLK);
      #1;
      check("reset_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                              CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
      RST = 1'b1;
      repeat (2) @(posedge CLK);

      for (int i = 0; i < 8; i++) apply(vecs[i]);

      // Reset while waiting on the ALU: outputs clear at once, result never transmitted.
      ALU_OUT = 16'h1234;
      exp_alu.push_back(4'h2);
      send_byte(8'hDD);
      RX_P_DATA = 8'h02;
      @(posedge CLK); #1;
      RX_D_VLD = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD = 1'b0;
      @(posedge CLK); #1;
      check("alu_en_before_rst", {ALU_EN, CLK_GATE_EN}, 2'b11);
      #2;
      RST = 1'b0;
      #1;
      check("outputs_on_mid_rst", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                                   CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      repeat (10) @(posedge CLK);
      check("alu_event_consumed", exp_alu.size(), 0);
      apply(vecs[1]);

      check("final_wr_queue", exp_wr.size(), 0);
      check("final_tx_queue", exp_tx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sys_cmd_decoder.md
Name: sys_cmd_decoder

Overview:
Command-parsing controller sitting directly downstream of the UART receiver in the REF_CLK domain. It consumes synchronized received bytes, decodes the four frame commands (0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands), and drives the register file and ALU. Results are pushed into the async TX FIFO feeding the UART transmitter. Operand registers are RF addresses 0 (A) and 1 (B).

Parameters:
DATA_WIDTH, 8, byte width of RX/TX data and RF data
ADDR_WIDTH, 4, register-file address width
ALU_FUN_WIDTH, 4, ALU function code width

Ports:
CLK  input  1  REF_CLK-domain clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte, valid when RX_D_VLD=1
RX_D_VLD  input  1  one-cycle pulse per received byte
RF_RdData  input  DATA_WIDTH  register-file read data
RF_RdData_VLD  input  1  read data valid, one cycle after RF_RdEn
ALU_OUT  input  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  input  1  ALU result valid
FIFO_FULL  input  1  TX FIFO full
RF_WrEn  output  1  RF write strobe
RF_RdEn  output  1  RF read strobe
RF_Address  output  ADDR_WIDTH  RF address
RF_WrData  output  DATA_WIDTH  RF write data
ALU_EN  output  1  ALU enable
ALU_FUN  output  ALU_FUN_WIDTH  ALU function code
CLK_GATE_EN  output  1  ALU clock-gate enable
TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  output  1  TX FIFO write strobe

Behaviour:
- One clock (CLK), reset asynchronous active-low (RST). On reset: state IDLE, all strobes/enables 0, RF_Address/RF_WrData/ALU_FUN/TX_P_DATA 0.
- All outputs registered; strobes (RF_WrEn, RF_RdEn, TX_D_VLD) are single-cycle pulses.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD.
- IDLE: on RX_D_VLD: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->FUN; any other byte ignored, stay IDLE.
- WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] as address (upper bits discarded) -> WR_DATA.
- WR_DATA: on byte, next cycle RF_WrEn=1 with latched address and data -> IDLE. No TX output.
- RD_ADDR: on byte, next cycle RF_RdEn=1 with address -> RD_WAIT; on RF_RdData_VLD capture data -> TX_RD.
- OP_A / OP_B: on byte, RF_WrEn pulse to address 0 / 1 with that byte; OP_A->OP_B->FUN.
- FUN: on byte, ALU_FUN=RX_P_DATA[ALU_FUN_WIDTH-1:0], CLK_GATE_EN=1, next cycle ALU_EN=1 -> ALU_WAIT.
- CLK_GATE_EN asserted from FUN byte until ALU_OUT_VLD received; ALU_EN held until ALU_OUT_VLD.
- ALU_WAIT: on ALU_OUT_VLD capture 16-bit result, drop ALU_EN/CLK_GATE_EN -> TX_LSB.
- TX_LSB: emit result[7:0] -> TX_MSB emits result[15:8] -> IDLE. TX_RD: emit read byte -> IDLE.
- TX emission: TX_D_VLD pulses only in a cycle where FIFO_FULL=0; while FIFO_FULL=1 the state holds, no data lost, no strobe.
- RX_D_VLD arriving in wait/TX states (RD_WAIT, ALU_WAIT, TX_*) is dropped; no command queuing.
- RF_WrEn and RF_RdEn never asserted together; ALU_EN never coincides with RF strobes.
- Reset mid-command: immediate return to IDLE, pending result discarded, no TX strobe.

Test Plan:
- Bytes AA,04,95 -> single RF_WrEn pulse, RF_Address=4, RF_WrData=0x95; TX_D_VLD never asserted.
- Bytes BB,04 with RF model returning 0x95 -> one RF_RdEn pulse at address 4, then TX_D_VLD once with TX_P_DATA=0x95.
- Bytes CC,8A,85,00 with ALU model returning 0x010F -> RF writes addr0=0x8A, addr1=0x85; ALU_EN with ALU_FUN=0; TX bytes 0x0F then 0x01.
- Bytes DD,02 with ALU_OUT=0x7552 and FIFO_FULL=1 for 20 cycles -> no TX_D_VLD while full; then 0x52, 0x75 in order; CLK_GATE_EN low after ALU_OUT_VLD.
- Byte 5A then AA,14,33 -> 5A ignored; write to address 4 (truncated) with data 0x33.
- RST asserted in ALU_WAIT -> all outputs 0 immediately; subsequent BB,04 decoded normally.
